// File: rtl/jtflane_arb_pkg.sv
// Shared definitions for the jtflane four-slot SDRAM arbiter.
package jtflane_arb_pkg;

    localparam int NSLOTS   = 4;
    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

endpackage

// File: rtl/jtflane_arb_entry.sv
// Single-word cache entry for one arbiter slot: tag compare, valid, data.
module jtflane_arb_entry #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          grab,
    input  logic          fill,
    input  logic          fill_valid,
    input  logic [15:0]   fill_data,
    output logic          ok,
    output logic [15:0]   dout,
    output logic          pending
);

    logic          valid;
    logic [AW-1:0] tag;
    logic [AW-1:0] req_tag;
    logic [15:0]   data;

    assign ok      = cs && valid && (tag == addr);
    assign pending = cs && !ok;
    assign dout    = data;

    // The tag comes from the address seen at grant time, not at fill time
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            tag     <= '0;
            req_tag <= '0;
            data    <= '0;
        end else begin
            if (grab) req_tag <= addr;
            if (fill) begin
                tag   <= req_tag;
                data  <= fill_data;
                valid <= fill_valid;
            end else if (clr) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtflane_sdram_arb.sv
// Four-slot SDRAM read arbiter with one cached word per slot.
// Define JTFLANE_ARB_RR_EN for round-robin grant; default is fixed priority.
module jtflane_sdram_arb
    import jtflane_arb_pkg::*;
#(
    parameter int          SLOT0_AW     = 18,
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter int          SLOT1_AW     = 17,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter int          SLOT2_AW     = 17,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter int          SLOT3_AW     = 17,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                slot0_cs,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    output logic                slot0_ok,
    output logic [15:0]         slot0_dout,
    input  logic                slot1_cs,
    input  logic [SLOT1_AW-1:0] slot1_addr,
    output logic                slot1_ok,
    output logic [15:0]         slot1_dout,
    input  logic                slot2_cs,
    input  logic [SLOT2_AW-1:0] slot2_addr,
    output logic                slot2_ok,
    output logic [15:0]         slot2_dout,
    input  logic                slot3_cs,
    input  logic [SLOT3_AW-1:0] slot3_addr,
    output logic                slot3_ok,
    output logic [15:0]         slot3_dout,
    output logic                sdram_req,
    output logic [21:0]         sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [15:0]         data_read
);

    state_t              state, state_nx;
    logic                req_nx;
    logic [SDRAM_AW-1:0] addr_nx;
    logic [1:0]          gnt, gnt_nx;
    logic                dirty, dirty_nx;
    logic [NSLOTS-1:0]   pending, grab, fill;
    logic                fill_valid;
    logic [1:0]          sel;
    logic                go;
    logic [SDRAM_AW-1:0] full [NSLOTS];

    assign full[0] = SDRAM_AW'(slot0_addr) + SLOT0_OFFSET;
    assign full[1] = SDRAM_AW'(slot1_addr) + SLOT1_OFFSET;
    assign full[2] = SDRAM_AW'(slot2_addr) + SLOT2_OFFSET;
    assign full[3] = SDRAM_AW'(slot3_addr) + SLOT3_OFFSET;

    // A fetch that overlapped a download must not be trusted
    assign fill_valid = !downloading && !dirty;
    assign go = (state == IDLE) && (|pending) && !downloading;

`ifdef JTFLANE_ARB_RR_EN
    logic [1:0] rr_ptr;

    always_comb begin
        sel = 2'd0;
        for (int i = NSLOTS; i >= 1; i--) begin
            if (pending[rr_ptr + 2'(i)]) sel = rr_ptr + 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     rr_ptr <= 2'd3;
        else if (go) rr_ptr <= sel;
    end
`else
    always_comb begin
        sel = 2'd0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (pending[i]) sel = 2'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            gnt        <= 2'd0;
            dirty      <= 1'b0;
        end else begin
            state      <= state_nx;
            sdram_req  <= req_nx;
            sdram_addr <= addr_nx;
            gnt        <= gnt_nx;
            dirty      <= dirty_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = sdram_req;
        addr_nx  = sdram_addr;
        gnt_nx   = gnt;
        dirty_nx = dirty;
        grab     = '0;
        fill     = '0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    grab[sel] = 1'b1;
                    gnt_nx    = sel;
                    addr_nx   = full[sel];
                    req_nx    = 1'b1;
                    dirty_nx  = 1'b0;
                    state_nx  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (downloading) dirty_nx = 1'b1;
                if (sdram_ack) begin
                    req_nx   = 1'b0;
                    state_nx = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (downloading) dirty_nx = 1'b1;
                if (data_rdy) begin
                    fill[gnt] = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: begin
                req_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    jtflane_arb_entry #(.AW(SLOT0_AW)) u_entry0 (
        .clk(clk), .rst(rst), .clr(downloading),
        .cs(slot0_cs), .addr(slot0_addr),
        .grab(grab[0]), .fill(fill[0]),
        .fill_valid(fill_valid), .fill_data(data_read),
        .ok(slot0_ok), .dout(slot0_dout), .pending(pending[0])
    );

    jtflane_arb_entry #(.AW(SLOT1_AW)) u_entry1 (
        .clk(clk), .rst(rst), .clr(downloading),
        .cs(slot1_cs), .addr(slot1_addr),
        .grab(grab[1]), .fill(fill[1]),
        .fill_valid(fill_valid), .fill_data(data_read),
        .ok(slot1_ok), .dout(slot1_dout), .pending(pending[1])
    );

    jtflane_arb_entry #(.AW(SLOT2_AW)) u_entry2 (
        .clk(clk), .rst(rst), .clr(downloading),
        .cs(slot2_cs), .addr(slot2_addr),
        .grab(grab[2]), .fill(fill[2]),
        .fill_valid(fill_valid), .fill_data(data_read),
        .ok(slot2_ok), .dout(slot2_dout), .pending(pending[2])
    );

    jtflane_arb_entry #(.AW(SLOT3_AW)) u_entry3 (
        .clk(clk), .rst(rst), .clr(downloading),
        .cs(slot3_cs), .addr(slot3_addr),
        .grab(grab[3]), .fill(fill[3]),
        .fill_valid(fill_valid), .fill_data(data_read),
        .ok(slot3_ok), .dout(slot3_dout), .pending(pending[3])
    );

endmodule
